// File: rtl/pong_pkg.sv
// Shared definitions for the pong controller: state codes, state type,
// player-index width and the wrap-around player index helper.
package pong_pkg;

  localparam int PIDX_W = 2;

  typedef enum logic [7:0] {
    ST_IDLE  = 8'h01,
    ST_SERVE = 8'h02,
    ST_RALLY = 8'h04,
    ST_POINT = 8'h08,
    ST_OVER  = 8'h10
  } state_t;

  // Next player index, wrapping at the number of active players.
  function automatic logic [PIDX_W-1:0] next_idx(input logic [PIDX_W-1:0] idx,
                                                 input logic [PIDX_W:0]   active);
    logic [PIDX_W:0] n;
    n = {1'b0, idx} + {{PIDX_W{1'b0}}, 1'b1};
    if (n >= active) return '0;
    return n[PIDX_W-1:0];
  endfunction

endpackage

// File: rtl/pong_score_bank.sv
// Per-player score counters: synchronous clear, single indexed increment,
// saturation at the all-ones value.
module pong_score_bank
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           clr,
  input  logic                           inc,
  input  logic [PIDX_W-1:0]              idx,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score
);

  localparam logic [SCORE_W-1:0] SMAX = '1;

  // Score storage; clear wins over increment.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      score <= '0;
    end else if (clr) begin
      score <= '0;
    end else if (inc) begin
      for (int i = 0; i < NUM_PLAYERS; i++) begin
        if (idx == PIDX_W'(i) && score[i*SCORE_W +: SCORE_W] != SMAX)
          score[i*SCORE_W +: SCORE_W] <= score[i*SCORE_W +: SCORE_W] + SCORE_W'(1);
      end
    end
  end

endmodule

// File: rtl/pong_controller_np.sv
// Pong game controller for 2..4 paddle channels (solo or multiplayer).
// Optional build macro PONG_WIN_BY_TWO_EN: a win needs WIN_SCORE points and
// a lead of two over every other active player (reaching the saturated score
// also wins). Without it, a player wins on reaching exactly WIN_SCORE.
module pong_controller_np
  import pong_pkg::*;
#(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W     = 4,
  parameter int WIN_SCORE   = 7,
  parameter int LVL_W       = 3,
  parameter int HIT_W       = 8
) (
  input  logic                           Clk,
  input  logic                           Rst_n,
  input  logic                           Start,
  input  logic                           Mode,
  input  logic [NUM_PLAYERS-1:0]         Hit,
  input  logic [NUM_PLAYERS-1:0]         Miss,
  input  logic                           T_serve,
  input  logic                           T_lvl,
  output logic [7:0]                     State,
  output logic                           T_serve_en,
  output logic                           T_lvl_en,
  output logic [HIT_W-1:0]               Hit_cnt,
  output logic [LVL_W-1:0]               Level,
  output logic [1:0]                     Turn,
  output logic [NUM_PLAYERS*SCORE_W-1:0] Score,
  output logic [1:0]                     Winner,
  output logic                           Winner_vld
);

  localparam logic [SCORE_W-1:0] SMAX = '1;
  localparam logic [LVL_W-1:0]   LMAX = '1;
  localparam logic [HIT_W-1:0]   HMAX = '1;

  state_t              state, state_nxt;
  logic [PIDX_W:0]     active, active_nxt;
  logic [PIDX_W-1:0]   server, server_nxt;
  logic [PIDX_W-1:0]   turn, turn_nxt;
  logic [PIDX_W-1:0]   last_hitter, last_nxt;
  logic [HIT_W-1:0]    hit_cnt, hit_nxt;
  logic [LVL_W-1:0]    level, level_nxt;
  logic [PIDX_W-1:0]   winner, winner_nxt;
  logic                sc_clr, sc_inc;
  logic [SCORE_W-1:0]  cur_score, new_score;
  logic                win;
  logic [3:0]          hit_v, miss_v;

  assign hit_v  = 4'(Hit);
  assign miss_v = 4'(Miss);

  pong_score_bank #(
    .NUM_PLAYERS (NUM_PLAYERS),
    .SCORE_W     (SCORE_W)
  ) u_score_bank (
    .clk   (Clk),
    .rst_n (Rst_n),
    .clr   (sc_clr),
    .inc   (sc_inc),
    .idx   (last_hitter),
    .score (Score)
  );

  // Win decision on the score the last hitter is about to receive.
  always_comb begin
    cur_score = '0;
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (last_hitter == PIDX_W'(i)) cur_score = Score[i*SCORE_W +: SCORE_W];
    new_score = (cur_score == SMAX) ? cur_score : cur_score + SCORE_W'(1);
`ifdef PONG_WIN_BY_TWO_EN
    win = (int'(new_score) >= WIN_SCORE);
    for (int i = 0; i < NUM_PLAYERS; i++)
      if (i < int'(active) && last_hitter != PIDX_W'(i) &&
          int'(new_score) < int'(Score[i*SCORE_W +: SCORE_W]) + 2)
        win = 1'b0;
    if (new_score == SMAX) win = 1'b1;
`else
    win = (int'(new_score) == WIN_SCORE);
`endif
  end

  // Next-state and next-register values for the game FSM.
  always_comb begin
    state_nxt  = state;
    active_nxt = active;
    server_nxt = server;
    turn_nxt   = turn;
    last_nxt   = last_hitter;
    hit_nxt    = hit_cnt;
    level_nxt  = level;
    winner_nxt = winner;
    sc_clr     = 1'b0;
    sc_inc     = 1'b0;
    case (state)
      ST_IDLE, ST_OVER: begin
        if (Start) begin
          state_nxt  = ST_SERVE;
          active_nxt = Mode ? (PIDX_W+1)'(NUM_PLAYERS) : (PIDX_W+1)'(1);
          server_nxt = '0;
          last_nxt   = '0;
          turn_nxt   = next_idx('0, active_nxt);
          hit_nxt    = '0;
          level_nxt  = '0;
          winner_nxt = '0;
          sc_clr     = 1'b1;
        end
      end
      ST_SERVE: begin
        if (T_serve) state_nxt = ST_RALLY;
      end
      ST_RALLY: begin
        if (T_lvl && level != LMAX) level_nxt = level + LVL_W'(1);
        // A miss by the expected hitter ends the rally even if it also hit.
        if (miss_v[turn]) begin
          if (active == (PIDX_W+1)'(1)) begin
            state_nxt  = ST_OVER;
            winner_nxt = '0;
          end else begin
            state_nxt  = ST_POINT;
          end
        end else if (hit_v[turn]) begin
          if (hit_cnt != HMAX) hit_nxt = hit_cnt + HIT_W'(1);
          last_nxt = turn;
          turn_nxt = next_idx(turn, active);
        end
      end
      ST_POINT: begin
        sc_inc     = 1'b1;
        hit_nxt    = '0;
        server_nxt = next_idx(server, active);
        if (win) begin
          state_nxt  = ST_OVER;
          winner_nxt = last_hitter;
        end else begin
          state_nxt  = ST_SERVE;
          last_nxt   = server_nxt;
          turn_nxt   = next_idx(server_nxt, active);
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // State and game registers, cleared asynchronously by reset.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state       <= ST_IDLE;
      active      <= (PIDX_W+1)'(1);
      server      <= '0;
      turn        <= '0;
      last_hitter <= '0;
      hit_cnt     <= '0;
      level       <= '0;
      winner      <= '0;
    end else begin
      state       <= state_nxt;
      active      <= active_nxt;
      server      <= server_nxt;
      turn        <= turn_nxt;
      last_hitter <= last_nxt;
      hit_cnt     <= hit_nxt;
      level       <= level_nxt;
      winner      <= winner_nxt;
    end
  end

  assign State      = state;
  assign T_serve_en = (state == ST_SERVE);
  assign T_lvl_en   = (state == ST_RALLY);
  assign Winner_vld = (state == ST_OVER);
  assign Hit_cnt    = hit_cnt;
  assign Level      = level;
  assign Turn       = turn;
  assign Winner     = winner;

endmodule
